// File: rtl/fetch_unit.sv
// PC / fetch sequencer in front of a 1-cycle registered, byte-addressed, big-endian instruction memory.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / bubble_count outputs.
module fetch_unit #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0]  HALT_WORD = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [WIDTH-1:0]  imem_data,
  output logic [WIDTH-1:0]  instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       bubble_count
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              pending_q;
  logic              halted_q;

  logic              in_fetch;
  logic              halt_hit;
  logic              consume;
  logic [ADDR_W-1:0] redirect_pc;
  logic              unused_redirect_lsb;

  always_comb begin
    in_fetch            = (state_q == StFetch);
    instr               = imem_data;
    imem_addr           = pc_q;
    instr_pc            = instr_pc_q;
    halted              = halted_q;
    instr_valid         = in_fetch && pending_q;
    consume             = instr_valid && !stall;
    halt_hit            = consume && (imem_data == HALT_WORD);
    imem_rd_en          = in_fetch && !stall && !redirect_valid && !halt_hit;
    redirect_pc         = {redirect_addr[ADDR_W-1:1], 1'b0};
    unused_redirect_lsb = redirect_addr[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      pending_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          // Priority: redirect > halt > stall > issue.
          if (redirect_valid) begin
            pc_q      <= redirect_pc;
            pending_q <= 1'b0;
          end else if (halt_hit) begin
            state_q   <= StHalt;
            pc_q      <= instr_pc_q;
            pending_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (!stall) begin
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + ADDR_W'(2);
            pending_q  <= 1'b1;
          end
        end
        StHalt: begin
          if (redirect_valid) begin
            state_q  <= StFetch;
            pc_q     <= redirect_pc;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;
  logic [15:0] bubble_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (consume && fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
      if (in_fetch && !instr_valid && bubble_count_q != 16'hFFFF) begin
        bubble_count_q <= bubble_count_q + 16'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan scenarios with literal expectations, then randomized
// stimulus, all compared every cycle against a stream-level reference model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_addr = '0;
  logic [5:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;
`endif

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [7:0] mem [64];

  function automatic logic [15:0] word(input int a);
    int b;
    b = a & 62;
    return {mem[b], mem[b + 1]};
  endfunction

  // Memory: registered read, output held while read enable is low.
  always @(posedge clock) if (imem_rd_en) imem_data <= word(int'(imem_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 halted. cur_* is the instruction presented to
  // decode; next_pc is the address of the next fetch.
  int         m_mode;
  bit         m_cur_valid;
  int         m_cur_pc;
  int         m_next_pc;
  int         m_fc;
  int         m_bc;

  function automatic bit m_consume();
    return (m_mode == 1) && m_cur_valid && !stall;
  endfunction

  function automatic bit m_halt_hit();
    return m_consume() && (word(m_cur_pc) == 16'h0000);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode      <= 0;
      m_cur_valid <= 1'b0;
      m_cur_pc    <= 0;
      m_next_pc   <= 0;
      m_fc        <= 0;
      m_bc        <= 0;
    end else if (m_mode == 0) begin
      if (run) m_mode <= 1;
    end else if (m_mode == 1) begin
      if (m_consume()) m_fc <= (m_fc < 65535) ? m_fc + 1 : m_fc;
      if (!m_cur_valid) m_bc <= (m_bc < 65535) ? m_bc + 1 : m_bc;
      if (redirect_valid) begin
        m_next_pc   <= int'(redirect_addr) & 62;
        m_cur_valid <= 1'b0;
      end else if (m_halt_hit()) begin
        m_mode      <= 2;
        m_cur_valid <= 1'b0;
        m_next_pc   <= m_cur_pc;
      end else if (!stall) begin
        m_cur_valid <= 1'b1;
        m_cur_pc    <= m_next_pc;
        m_next_pc   <= (m_next_pc + 2) % 64;
      end
    end else if (redirect_valid) begin
      m_mode    <= 1;
      m_next_pc <= int'(redirect_addr) & 62;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("imem_rd_en", imem_rd_en,
            (m_mode == 1) && !stall && !redirect_valid && !m_halt_hit());
      check("instr_valid", instr_valid, (m_mode == 1) && m_cur_valid);
      check("halted", halted, m_mode == 2);
      check("imem_addr", imem_addr, m_next_pc);
      if (m_mode == 1 && m_cur_valid) begin
        check("instr", instr, word(m_cur_pc));
        check("instr_pc", instr_pc, m_cur_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, m_fc);
      check("bubble_count", bubble_count, m_bc);
`endif
    end
  end

  task automatic adv();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic expect_instr(input string name, input logic [15:0] w, input logic [5:0] pc);
    check({name, "_valid"}, instr_valid, 1'b1);
    check({name, "_instr"}, instr, w);
    check({name, "_pc"}, instr_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hFE; mem[1] = 8'h21; mem[2] = 8'hFB; mem[3] = 8'h22;
    mem[4] = 8'h23; mem[5] = 8'h88; mem[26] = 8'hA6; mem[27] = 8'h94;
    mem[60] = 8'h12; mem[61] = 8'h34; mem[62] = 8'h00; mem[63] = 8'h00;

    repeat (2) adv();
    cmp_en = 1'b1;
    settle();
    check("rst_rd_en", imem_rd_en, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", imem_addr, 6'h00);
    check("rst_instr_pc", instr_pc, 6'h00);
    adv();
    reset = 1'b1;

    // 1: run pulse, sequential fetch.
    run = 1'b1;
    adv();
    run = 1'b0;
    settle();
    check("s1_bubble", instr_valid, 1'b0);
    adv(); settle(); expect_instr("s1_a", 16'hFE21, 6'h00);
    adv(); settle(); expect_instr("s1_b", 16'hFB22, 6'h02);

    // 2: three stall edges while 0xFB22 is presented.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_instr("s2_hold", 16'hFB22, 6'h02);
      check("s2_rd_en", imem_rd_en, 1'b0);
      adv(); settle();
    end
    stall = 1'b0;
    #1;
    expect_instr("s2_last", 16'hFB22, 6'h02);
    adv(); settle(); expect_instr("s2_next", 16'h2388, 6'h04);

    // 3: redirect to 0, then to 0x1B while 0xFE21 is valid.
    redirect_valid = 1'b1; redirect_addr = 6'h00;
    adv(); redirect_valid = 1'b0;
    adv(); settle(); expect_instr("s3_start", 16'hFE21, 6'h00);
    redirect_valid = 1'b1; redirect_addr = 6'h1B;
    adv(); redirect_valid = 1'b0;
    settle();
    check("s3_bubble", instr_valid, 1'b0);
    check("s3_addr", imem_addr, 6'h1A);
    adv(); settle(); expect_instr("s3_tgt", 16'hA694, 6'h1A);
    adv(); settle();
    check("s3_cont_pc", instr_pc, 6'h1C);

    // 4: run into the halt word at 0x3E, then resume with a redirect to 0.
    redirect_valid = 1'b1; redirect_addr = 6'h3C;
    adv(); redirect_valid = 1'b0;
    adv(); settle(); expect_instr("s4_a", 16'h1234, 6'h3C);
    adv(); settle(); expect_instr("s4_halt", 16'h0000, 6'h3E);
    check("s4_hit_rd_en", imem_rd_en, 1'b0);
    run = 1'b1;
    adv(); run = 1'b0;
    adv(); settle();
    check("s4_halted", halted, 1'b1);
    check("s4_valid", instr_valid, 1'b0);
    check("s4_rd_en", imem_rd_en, 1'b0);
    check("s4_addr", imem_addr, 6'h3E);
    redirect_valid = 1'b1; redirect_addr = 6'h00;
    adv(); redirect_valid = 1'b0;
    settle();
    check("s4_unhalt", halted, 1'b0);
    adv(); settle(); expect_instr("s4_resume", 16'hFE21, 6'h00);

    // 5: async reset mid-stream with stall asserted.
    stall = 1'b1;
    adv();
    reset = 1'b0;
    #1;
    check("s5_rd_en", imem_rd_en, 1'b0);
    check("s5_valid", instr_valid, 1'b0);
    check("s5_halted", halted, 1'b0);
    check("s5_addr", imem_addr, 6'h00);
    check("s5_instr_pc", instr_pc, 6'h00);
    adv();
    reset = 1'b1; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv(); settle();
      check("s5_idle_valid", instr_valid, 1'b0);
      check("s5_idle_rd_en", imem_rd_en, 1'b0);
    end
    adv();

    // Randomized phase, checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 6'($urandom);
      run            = ($urandom_range(0, 7) == 0);
      reset          = ($urandom_range(0, 299) != 0);
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
